// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and FSM state type for the DDS SPI writer.
// Build option DDS_IOUPDATE_EN adds the IOUP state to the enum.
package dds_pkg;

    localparam int INSTR_W   = 8;
    localparam int DATA_W    = 32;
    localparam int XFER_BITS = 40;
    localparam int READ_BIT  = 7;
    localparam int BIT_W     = 6;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        HOLD,
`ifdef DDS_IOUPDATE_EN
        IOUP,
`endif
        DONE
    } state_t;

endpackage

// File: rtl/dds_spi_writer_if.sv
// dds_spi_writer_if: request/response bus of the DDS SPI writer.
// master drives wr_start/wr_addr/wr_data; slave returns wr_done/wr_out/busy.
interface dds_spi_writer_if;
    import dds_pkg::*;

    logic               wr_start;
    logic [INSTR_W-1:0] wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_done;
    logic [DATA_W-1:0]  wr_out;
    logic               busy;

    modport master (
        output wr_start, wr_addr, wr_data,
        input  wr_done, wr_out, busy
    );

    modport slave (
        input  wr_start, wr_addr, wr_data,
        output wr_done, wr_out, busy
    );

endinterface

// File: rtl/dds_sclk_gen.sv
// dds_sclk_gen: SCLK half-period timer and bit counter for one 40-bit frame.
// Ports: clk, rst, run (frame active), sclk, rise/fall (next edge moves
// SCLK up/down), last (fall of the final bit), bit_idx (current bit 0..39).
module dds_sclk_gen
    import dds_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             sclk,
    output logic             rise,
    output logic             fall,
    output logic             last,
    output logic [BIT_W-1:0] bit_idx
);

    localparam logic [7:0]       HALF_END = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(XFER_BITS - 1);

    logic [7:0] half_cnt;
    logic       half_end;

    // Strobes are valid in the cycle before the edge they describe,
    // so the FSM acts on exactly the edge that moves SCLK.
    assign half_end = run && (half_cnt == HALF_END);
    assign rise     = half_end && !sclk;
    assign fall     = half_end && sclk;
    assign last     = fall && (bit_idx == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
            sclk     <= 1'b0;
            bit_idx  <= '0;
        end else if (!run) begin
            half_cnt <= '0;
            sclk     <= 1'b0;
            bit_idx  <= '0;
        end else if (half_end) begin
            half_cnt <= '0;
            sclk     <= ~sclk;
            if (sclk) begin
                bit_idx <= last ? '0 : bit_idx + 6'd1;
            end
        end else begin
            half_cnt <= half_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dds_spi_writer.sv
// dds_spi_writer: 40-bit SPI frame writer/reader for a DDS register file.
// Ports: clk, rst, bus (dds_spi_writer_if.slave: wr_start, wr_addr, wr_data,
// wr_done, wr_out, busy), SCLK, CS_N, SDIO, SDO, IO_UPDATE.
// Build option DDS_IOUPDATE_EN: pulse IO_UPDATE after every write.
module dds_spi_writer
    import dds_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int IOUP_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    dds_spi_writer_if.slave bus,
    output logic            SCLK,
    output logic            CS_N,
    output logic            SDIO,
    input  logic            SDO,
    output logic            IO_UPDATE
);

    localparam logic [7:0] HOLD_END = 8'(CLK_DIV - 1);
    localparam logic [7:0] IOUP_END = 8'(IOUP_LEN);

    state_t               state;
    state_t               state_d;
    logic [7:0]           cnt;
    logic [7:0]           cnt_d;
    logic                 cnt_end;
    logic                 hold_end;
    logic                 accept;

    logic [XFER_BITS-1:0] sr;
    logic [DATA_W-1:0]    cap;
    logic [DATA_W-1:0]    out_q;
    logic                 is_rd;
    logic                 cs_n_q;

    logic                 run;
    logic                 sclk;
    logic                 rise;
    logic                 fall;
    logic                 last;
    logic [BIT_W-1:0]     bit_idx;

    assign run = (state == SHIFT);

    dds_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .sclk    (sclk),
        .rise    (rise),
        .fall    (fall),
        .last    (last),
        .bit_idx (bit_idx)
    );

    assign accept = (state == IDLE) && bus.wr_start;

    // One counter times both HOLD (CLK_DIV cycles) and IOUP
    // (IOUP_LEN high cycles plus one low cycle before DONE).
    assign cnt_end  = (state == HOLD) ? (cnt == HOLD_END)
                                      : (cnt == IOUP_END);
    assign hold_end = (state == HOLD) && cnt_end;

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        unique case (state)
            IDLE: begin
                if (bus.wr_start) state_d = SHIFT;
            end
            SHIFT: begin
                if (last) state_d = HOLD;
            end
            HOLD: begin
                if (cnt_end) begin
`ifdef DDS_IOUPDATE_EN
                    state_d = is_rd ? DONE : IOUP;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef DDS_IOUPDATE_EN
            IOUP: begin
                if (cnt_end) state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == state && state != IDLE && state != SHIFT) begin
            cnt_d = cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // SDIO is the shift register MSB: loaded on accept, advanced only on
    // SCLK falls, so it is stable across every rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= '0;
            cap    <= '0;
            out_q  <= '0;
            is_rd  <= 1'b0;
            cs_n_q <= 1'b1;
        end else begin
            if (accept) begin
                sr     <= {bus.wr_addr, bus.wr_data};
                is_rd  <= bus.wr_addr[READ_BIT];
                cs_n_q <= 1'b0;
            end else if (fall) begin
                sr <= {sr[XFER_BITS-2:0], 1'b0};
            end
            if (rise && is_rd && bit_idx >= BIT_W'(INSTR_W)) begin
                cap <= {cap[DATA_W-2:0], SDO};
            end
            if (hold_end) begin
                cs_n_q <= 1'b1;
                if (is_rd) out_q <= cap;
            end
        end
    end

`ifdef DDS_IOUPDATE_EN
    logic iou_q;

    // Rises with CS_N after a write, drops after IOUP_LEN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iou_q <= 1'b0;
        end else if (hold_end && !is_rd) begin
            iou_q <= 1'b1;
        end else if (state == IOUP && cnt == IOUP_END - 8'd1) begin
            iou_q <= 1'b0;
        end
    end

    assign IO_UPDATE = iou_q;
`else
    assign IO_UPDATE = 1'b0;
`endif

    assign SCLK        = sclk;
    assign CS_N        = cs_n_q;
    assign SDIO        = sr[XFER_BITS-1];
    assign bus.wr_done = (state == DONE);
    assign bus.busy    = (state != IDLE);
    assign bus.wr_out  = out_q;

endmodule

// File: tb/tb_dds_spi_writer.sv
// tb_dds_spi_writer: directed and random frames against a DDS pin model.
// Honours DDS_IOUPDATE_EN for the IO_UPDATE expectations.
`timescale 1ns/1ps
module tb_dds_spi_writer;
    import dds_pkg::*;

    localparam int CLK_DIV  = 2;
    localparam int IOUP_LEN = 4;
    localparam int CS_LOW   = 81 * CLK_DIV;
`ifdef DDS_IOUPDATE_EN
    localparam bit IOU_ON = 1'b1;
`else
    localparam bit IOU_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic SCLK;
    logic CS_N;
    logic SDIO;
    logic SDO;
    logic IO_UPDATE;

    dds_spi_writer_if bus ();

    dds_spi_writer #(
        .CLK_DIV  (CLK_DIV),
        .IOUP_LEN (IOUP_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SCLK      (SCLK),
        .CS_N      (CS_N),
        .SDIO      (SDIO),
        .SDO       (SDO),
        .IO_UPDATE (IO_UPDATE)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Pin-level observer and DDS slave model state.
    int          cyc = 0;
    int          nrise;
    int          windows;
    int          cur_win;
    int          last_win;
    int          rise_cyc;
    int          min_gap;
    int          gap;
    int          done_cnt;
    int          done_cyc;
    int          iou_cnt;
    int          iou_first;
    int          sdio_viol;
    logic [39:0] rx_bits;
    logic [31:0] done_out;
    logic [31:0] dds_word;
    logic        sclk_q = 1'b0;
    logic        sdio_q = 1'b0;
    logic        cs_q   = 1'b1;

    // Expected wr_out: last word read back since reset.
    logic [31:0] exp_out;
    logic [7:0]  ra;
    logic [31:0] rdat;
    logic [31:0] rword;

    always @(negedge clk) begin
        cyc++;
        if (!CS_N && cs_q) begin
            windows++;
            gap = cyc - rise_cyc;
            if (gap < min_gap) min_gap = gap;
            cur_win = 0;
        end
        if (!CS_N) cur_win++;
        if (CS_N && !cs_q) begin
            last_win = cur_win;
            rise_cyc = cyc;
        end
        if (bus.wr_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_out = bus.wr_out;
        end
        if (IO_UPDATE) begin
            if (iou_cnt == 0) iou_first = cyc;
            iou_cnt++;
        end
        if (SCLK && !sclk_q) begin
            rx_bits = {rx_bits[38:0], SDIO};
            nrise++;
        end
        if (SCLK && sclk_q && SDIO !== sdio_q) sdio_viol++;
        // DDS drives read data after each fall, bits 8..39 of the frame.
        if (!SCLK && sclk_q) begin
            if ((nrise % 40) >= 8) SDO = dds_word[39 - (nrise % 40)];
            else SDO = 1'b0;
        end
        sclk_q = SCLK;
        sdio_q = SDIO;
        cs_q   = CS_N;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        nrise     = 0;
        windows   = 0;
        cur_win   = 0;
        last_win  = 0;
        rise_cyc  = -1000000;
        min_gap   = 1000000;
        done_cnt  = 0;
        done_cyc  = 0;
        iou_cnt   = 0;
        iou_first = 0;
        sdio_viol = 0;
        rx_bits   = '0;
        done_out  = '0;
        SDO       = 1'b0;
    endtask

    task automatic start(input logic [7:0] a, input logic [31:0] d);
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_start = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_start = 1'b0;
        bus.wr_addr  = 8'($urandom);
        bus.wr_data  = $urandom;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.wr_done;
        end
        check({tag, ":done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic xfer(input string tag, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] w);
        logic rd;
        logic iou_exp;
        rd      = a[READ_BIT];
        iou_exp = IOU_ON && !rd;
        clr();
        dds_word = w;
        start(a, d);
        wait_done(tag);
        repeat (3) @(posedge clk);
        #1;
        if (rd) exp_out = w;
        check({tag, ":bits"}, 64'(rx_bits), 64'({a, d}));
        check({tag, ":cs_low"}, 64'(last_win), 64'(CS_LOW));
        check({tag, ":windows"}, 64'(windows), 64'd1);
        check({tag, ":done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, ":wr_out"}, 64'(done_out), 64'(exp_out));
        check({tag, ":iou_cycles"}, 64'(iou_cnt),
              64'(iou_exp ? IOUP_LEN : 0));
        // Edges from the one raising CS_N to the one sampling wr_done.
        check({tag, ":done_lag"}, 64'(done_cyc - rise_cyc + 1),
              64'(iou_exp ? IOUP_LEN + 2 : 1));
        check({tag, ":sdio_stable"}, 64'(sdio_viol), 64'd0);
        if (iou_exp) begin
            check({tag, ":iou_start"}, 64'(iou_first), 64'(rise_cyc));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        exp_out      = '0;
        dds_word     = '0;
        rst          = 1'b1;
        bus.wr_start = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        check("rst:cs_n", 64'(CS_N), 64'd1);
        check("rst:sclk", 64'(SCLK), 64'd0);
        check("rst:sdio", 64'(SDIO), 64'd0);
        check("rst:io_update", 64'(IO_UPDATE), 64'd0);
        check("rst:wr_done", 64'(bus.wr_done), 64'd0);
        check("rst:busy", 64'(bus.busy), 64'd0);
        check("rst:wr_out", 64'(bus.wr_out), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        xfer("wr_spec", 8'h02, 32'h1F3F_4000, 32'h0);
        xfer("rd_spec", 8'h82, 32'h0, 32'hA5C3_0F96);

        for (int i = 0; i < 5; i++) begin
            ra    = 8'($urandom);
            rdat  = $urandom;
            rword = $urandom;
            xfer($sformatf("rnd%0d", i), ra, rdat, rword);
        end

        // Second request 10 cycles into a frame is dropped.
        clr();
        start(8'h05, 32'h1234_5678);
        repeat (9) @(posedge clk);
        #1;
        bus.wr_addr  = 8'h06;
        bus.wr_data  = 32'hDEAD_BEEF;
        bus.wr_start = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_start = 1'b0;
        wait_done("ign");
        repeat (250) @(posedge clk);
        #1;
        check("ign:windows", 64'(windows), 64'd1);
        check("ign:done_cnt", 64'(done_cnt), 64'd1);
        check("ign:bits", 64'(rx_bits), 64'h05_1234_5678);

        // Request held only during the wr_done cycle is dropped.
        clr();
        start(8'h07, 32'hCAFE_0001);
        wait_done("dc");
        bus.wr_start = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("dc:busy", 64'(bus.busy), 64'd0);
        check("dc:windows", 64'(windows), 64'd1);

        // Reset at bit 20 of a write aborts it silently.
        clr();
        start(8'h03, 32'h8765_4321);
        for (int i = 0; i < 400 && nrise < 20; i++) begin
            @(posedge clk);
            #1;
        end
        check("abort:bit", 64'(nrise), 64'd20);
        #2;
        rst = 1'b1;
        #1;
        check("abort:cs_n", 64'(CS_N), 64'd1);
        check("abort:sclk", 64'(SCLK), 64'd0);
        check("abort:busy", 64'(bus.busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        exp_out = '0;
        check("abort:wr_out", 64'(bus.wr_out), 64'(exp_out));
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("abort:no_done", 64'(done_cnt), 64'd0);
        xfer("after_rst", 8'h04, 32'h0BAD_F00D, 32'h0);

        // Back-to-back: next request the cycle after wr_done.
        clr();
        start(8'h10, 32'h1111_2222);
        wait_done("b2b_a");
        @(posedge clk);
        #1;
        start(8'h11, 32'h3333_4444);
        wait_done("b2b_b");
        repeat (3) @(posedge clk);
        #1;
        check("b2b:windows", 64'(windows), 64'd2);
        check("b2b:done_cnt", 64'(done_cnt), 64'd2);
        check("b2b:cs_gap", 64'(min_gap),
              64'(IOU_ON ? IOUP_LEN + 3 : 2));
        check("b2b:bits", 64'(rx_bits), 64'h11_3333_4444);
        check("b2b:cs_low", 64'(last_win), 64'(CS_LOW));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_spi_writer.md
DDS_SPI_WRITER -- requirements
Module: dds_spi_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter IOUP_LEN, default 4: IO_UPDATE pulse width in clk cycles, legal range 1..255.
REQ-003 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_start  in  1  transaction request, sampled only in IDLE.
REQ-006 SHALL have port wr_addr  in  8  instruction byte: bit7 = read (1) / write (0), bits[4:0] = register address.
REQ-007 SHALL have port wr_data  in  32  write payload, MSB first.
REQ-008 SHALL have port wr_done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port wr_out  out  32  last read-back word.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port SCLK  out  1  serial clock; idles low.
REQ-012 SHALL have port CS_N  out  1  chip select; active low.
REQ-013 SHALL have port SDIO  out  1  serial data to the DDS.
REQ-014 SHALL have port SDO  in  1  serial data from the DDS, used for reads.
REQ-015 SHALL have port IO_UPDATE  out  1  DDS register-transfer strobe (see REQ-031).

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, HOLD, IOUP, DONE.
REQ-017 IDLE with wr_start=1 at an edge SHALL latch {wr_addr,wr_data} into a 40-bit shift register and enter SHIFT; CS_N=0 and SDIO=bit39 from that edge.
REQ-018 SHIFT SHALL send 40 bits MSB first; each bit is SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-019 SDIO SHALL change only on SCLK falling edges (or at entry to SHIFT), giving the DDS a stable value at each rising edge.
REQ-020 For reads (latched bit7=1), SDO SHALL be sampled on the clk edge that raises SCLK for bits 8..39 (data phase only) and shifted MSB first into a 32-bit capture register.
REQ-021 After the 40th high phase, SCLK SHALL return low and the FSM enters HOLD; CS_N stays low for CLK_DIV more cycles.
REQ-022 CS_N SHALL therefore be low for exactly 81*CLK_DIV cycles per transaction.
REQ-023 On leaving HOLD, CS_N SHALL go high, then:
  - write -> IOUP (REQ-031);
  - read -> DONE.
REQ-024 DONE SHALL assert wr_done for exactly one cycle and return to IDLE.
REQ-025 On a read, wr_out SHALL be loaded from the capture register in the DONE cycle; on a write, wr_out SHALL hold its previous value.
REQ-026 wr_start while busy=1 SHALL be ignored; no queuing.
REQ-027 wr_start in the same cycle as the DONE pulse SHALL be ignored; it is accepted from the next cycle, in IDLE.
REQ-028 wr_data and wr_addr changes after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-029 rst=1 SHALL force, regardless of state and including mid-transfer:
  - state = IDLE;
  - CS_N=1, SCLK=0, SDIO=0, IO_UPDATE=0;
  - wr_done=0, busy=0;
  - wr_out=32'd0, shift/capture registers cleared.
REQ-030 A transfer aborted by reset SHALL produce no wr_done pulse.

Configuration
REQ-031 With macro DDS_IOUPDATE_EN defined:
  - after a write, IOUP SHALL drive IO_UPDATE=1 for IOUP_LEN cycles starting the cycle CS_N rises;
  - IOUP then enters DONE, so wr_done pulses the cycle after IO_UPDATE falls;
  - reads SHALL skip IOUP.
REQ-032 Without DDS_IOUPDATE_EN:
  - the IOUP state is absent and IO_UPDATE is tied 0;
  - writes go HOLD -> DONE, like reads.

Structure
REQ-033 Package dds_pkg SHALL hold:
  - the FSM state enum;
  - INSTR_W=8, DATA_W=32, XFER_BITS=40, READ_BIT=7.
REQ-034 SCLK timing (half-period counter, rise/fall strobes, bit counter 0..39) SHALL be in sub-module dds_sclk_gen, instantiated once; the FSM and shifters stay in dds_spi_writer.

Verification (CLK_DIV=2, IOUP_LEN=4)
REQ-035 Write with wr_addr=8'h02, wr_data=32'h1F3F_4000 -> SDIO bits at SCLK rises = 40'h02_1F3F_4000, CS_N low 162 cycles, and:
  - macro on: IO_UPDATE high 4 cycles, one wr_done pulse 6 cycles after CS_N rises;
  - macro off: wr_done 1 cycle after CS_N rises, IO_UPDATE never high.
REQ-036 Read with wr_addr=8'h82 and DDS model returning 32'hA5C3_0F96 on SDO -> wr_out=32'hA5C3_0F96 in the wr_done cycle, and IO_UPDATE never high.
REQ-037 Second wr_start pulsed 10 cycles into a transfer -> ignored: exactly one CS_N low window and one wr_done pulse.
REQ-038 rst asserted at bit 20 of a write -> CS_N=1, SCLK=0 immediately, no wr_done; a new write afterwards completes normally.
REQ-039 Back-to-back writes, with wr_start asserted the cycle after wr_done -> second transaction accepted, and CS_N is high at least 1 cycle between the two windows.
